// File: rtl/uart_alu_pkg.sv
// Shared constants and types for the UART ALU command path.
// Holds the opcode values, the framing sizes and the parser state encoding.
package uart_alu_pkg;

  localparam logic [7:0] OP_ADD     = 8'h10;
  localparam logic [7:0] OP_MUL     = 8'h11;
  localparam int         HDR_BYTES  = 4;
  localparam int         OPND_BYTES = 4;

  typedef enum logic [2:0] {
    S_OPCODE,
    S_RSVD,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_DRAIN
  } parser_state_e;

  // A packet is forwarded only if it carries a known opcode and a whole, non-empty operand list.
  function automatic logic pkt_valid(input logic [7:0] opc, input logic [15:0] len);
    return ((opc == OP_ADD) || (opc == OP_MUL)) &&
           (len >= 16'(HDR_BYTES + OPND_BYTES)) &&
           (len[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/uart_packet_parser.sv
// Parses the UART ALU command stream into little-endian 32-bit operands.
// Malformed packets are drained and flagged with a one-cycle err_o pulse.
module uart_packet_parser
  import uart_alu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [31:0] op_data_o,
  output logic        op_valid_o,
  input  logic        op_ready_i,
  output logic        op_last_o,
  output logic [7:0]  opcode_o,
  output logic        err_o
);

  parser_state_e r_state, w_state_next;
  logic [1:0]    r_idx, w_idx_next;
  logic [15:0]   r_remaining, w_remaining_next;
  logic [23:0]   r_asm, w_asm_next;
  logic [7:0]    r_len_lo;
  logic [7:0]    r_pkt_opcode;
  logic [31:0]   r_op_data;
  logic          r_op_valid;
  logic          r_op_last;
  logic [7:0]    r_opcode;
  logic          r_err;

  logic          w_stall;
  logic          w_rx_fire;
  logic          w_out_free;
  logic          w_load;
  logic          w_err_next;
  logic [15:0]   w_len;
  logic [15:0]   w_rem_dec;

  // Only the operand-completing byte can be blocked, and only by a pending operand.
  assign w_stall    = (r_state == S_DATA) && (r_idx == 2'd3) && r_op_valid && !op_ready_i;
  assign rx_ready_o = !rst_i && !w_stall;
  assign w_rx_fire  = rx_valid_i && rx_ready_o;
  assign w_out_free = !r_op_valid || op_ready_i;
  assign w_len      = {rx_data_i, r_len_lo};
  assign w_rem_dec  = r_remaining - 16'd1;

  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_remaining_next = r_remaining;
    w_asm_next       = r_asm;
    w_load           = 1'b0;
    w_err_next       = 1'b0;
    if (w_rx_fire) begin
      case (r_state)
        S_OPCODE: w_state_next = S_RSVD;
        S_RSVD:   w_state_next = S_LEN_LO;
        S_LEN_LO: w_state_next = S_LEN_HI;
        S_LEN_HI: begin
          w_idx_next = 2'd0;
          if (pkt_valid(r_pkt_opcode, w_len)) begin
            w_state_next     = S_DATA;
            w_remaining_next = w_len - 16'(HDR_BYTES);
          end else if (w_len > 16'(HDR_BYTES)) begin
            w_state_next     = S_DRAIN;
            w_remaining_next = w_len - 16'(HDR_BYTES);
            w_err_next       = 1'b1;
          end else begin
            w_state_next     = S_OPCODE;
            w_remaining_next = 16'd0;
            w_err_next       = 1'b1;
          end
        end
        S_DATA: begin
          w_remaining_next = w_rem_dec;
          w_idx_next       = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            w_load = 1'b1;
            if (w_rem_dec == 16'd0) begin
              w_state_next = S_OPCODE;
            end
          end else begin
            // LSB arrives first, so shift right and insert at the top.
            w_asm_next = {rx_data_i, r_asm[23:8]};
          end
        end
        S_DRAIN: begin
          w_remaining_next = w_rem_dec;
          if (w_rem_dec == 16'd0) begin
            w_state_next = S_OPCODE;
          end
        end
        default: w_state_next = S_OPCODE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_OPCODE;
      r_idx        <= 2'd0;
      r_remaining  <= 16'd0;
      r_asm        <= 24'd0;
      r_len_lo     <= 8'd0;
      r_pkt_opcode <= 8'd0;
      r_op_data    <= 32'd0;
      r_op_valid   <= 1'b0;
      r_op_last    <= 1'b0;
      r_opcode     <= 8'd0;
      r_err        <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_remaining <= w_remaining_next;
      r_asm       <= w_asm_next;
      r_err       <= w_err_next;
      if (w_rx_fire && (r_state == S_OPCODE)) begin
        r_pkt_opcode <= rx_data_i;
      end
      if (w_rx_fire && (r_state == S_LEN_LO)) begin
        r_len_lo <= rx_data_i;
      end
      if (w_load) begin
        r_op_data  <= {rx_data_i, r_asm};
        r_op_valid <= 1'b1;
        r_op_last  <= (w_rem_dec == 16'd0);
      end else if (op_ready_i) begin
        r_op_valid <= 1'b0;
      end
      // The visible opcode never changes under a pending operand; it catches up once the slot frees.
      if (w_out_free) begin
        r_opcode <= (w_rx_fire && (r_state == S_OPCODE)) ? rx_data_i : r_pkt_opcode;
      end
    end
  end

  assign op_data_o  = r_op_data;
  assign op_valid_o = r_op_valid;
  assign op_last_o  = r_op_last;
  assign opcode_o   = r_opcode;
  assign err_o      = r_err;

endmodule

// File: doc/uart_packet_parser.md
# uart_packet_parser

- Receives the host-to-FPGA UART ALU command stream one byte at a time from the UART receiver.
- Parses the 4-byte header (opcode, reserved, length) and assembles the payload into little-endian 32-bit operands.
- Presents each operand on a valid/ready stream with the packet opcode and a last flag.
- Sits between the UART RX byte stream and the ALU datapath; malformed or unsupported packets are consumed and flagged, never forwarded.

## Interface
Parameters: none; all constants live in `uart_alu_pkg`.

- clk_i  in  1  sole clock
- rst_i  in  1  reset, synchronous, active-high
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  byte valid
- rx_ready_o  out  1  parser accepts byte; transfer when rx_valid_i && rx_ready_o
- op_data_o  out  32  assembled operand
- op_valid_o  out  1  operand valid
- op_ready_i  in  1  downstream accepts operand; transfer when op_valid_o && op_ready_i
- op_last_o  out  1  final operand of packet, qualified by op_valid_o
- opcode_o  out  8  opcode of the current packet, stable while op_valid_o
- err_o  out  1  one-cycle pulse on a rejected packet

## Operation
- **Packet format:** byte0 opcode, byte1 reserved (ignored), byte2 length[7:0], byte3 length[15:8].
  - length = total packet bytes including the header.
  - Payload bytes follow; each operand is 4 bytes, LSB first.
- **Supported opcodes:** OP_ADD = 8'h10, OP_MUL = 8'h11.
- **Valid packet:** supported opcode, length >= 8, and (length - 4) % 4 == 0.
- **States:**
  - S_OPCODE → S_RSVD → S_LEN_LO → S_LEN_HI, advancing one state per accepted byte.
  - At S_LEN_HI acceptance, the full length is known:
    - valid packet → S_DATA;
    - invalid, length > 4 → S_DRAIN with err_o pulse;
    - invalid, length <= 4 → S_OPCODE with err_o pulse.
  - S_DATA: byte index 0..3 and a 16-bit remaining-byte counter, initialised to length-4.
    - Bytes 0..2 shift into a 24-bit assembly register.
    - Byte 3 loads op_data_o = {byte3, assembly} and sets op_valid_o.
    - op_last_o = 1 when remaining reaches 0 after that byte, then the state returns to S_OPCODE.
  - S_DRAIN: accept and discard length-4 bytes, then return to S_OPCODE. No op_valid_o is ever raised for the packet.
- **Ready rules:**
  - rx_ready_o = 1 in every state except S_DATA with byte index 3 while op_valid_o && !op_ready_i.
  - Indices 0..2 are always accepted, even while an operand is pending.
- **Output register:** single entry.
  - op_valid_o clears on handshake unless a new operand loads in the same cycle; the load wins.
  - op_data_o, op_last_o and opcode_o hold until the handshake.
- **opcode_o** latches at S_OPCODE acceptance and holds until the next packet's opcode byte.
- **Length arithmetic:** 16-bit unsigned.
  - length 16'hFFFF is misaligned and is drained (65531 bytes).
  - Maximum valid operand count is (16'hFFFC - 4) / 4 = 16382.

## Timing
- **Reset values:** rx_ready_o 0 while rst_i is high; op_data_o 0, op_valid_o 0, op_last_o 0, opcode_o 0, err_o 0; state S_OPCODE, counters 0.
- rx_ready_o is combinational from state and output-register status, and is 1 in the first cycle after rst_i falls.
- **Latency:**
  - op_valid_o rises the cycle after the 4th operand byte handshake.
  - err_o pulses the cycle after the length[15:8] handshake.
- **Throughput:** with op_ready_i held high, one byte per cycle, no bubbles.
  - No bubbles between operands.
  - No bubbles between back-to-back packets: the opcode byte may arrive the cycle after the last payload byte.
- **Reset mid-packet:** partial header, assembly register and pending operand are discarded. The first byte after reset is parsed as an opcode.

## Structure
- **Package `uart_alu_pkg`:**
  - OP_ADD, OP_MUL
  - HDR_BYTES = 4, OPND_BYTES = 4
  - typedef enum parser_state_e {S_OPCODE, S_RSVD, S_LEN_LO, S_LEN_HI, S_DATA, S_DRAIN}
- Single module with no sub-module. The byte-to-word assembly and the one-entry output register are too small to split out.

## Test plan
- **Add packet:** 10 00 0C 00 01 00 00 00 02 00 00 00 with op_ready_i = 1 → beats 32'h1 (last 0) and 32'h2 (last 1), opcode_o 8'h10, err_o never high.
- **Backpressure:** OP_MUL, length 16'h0010, operands 5/6/7, op_ready_i low for 20 cycles → rx_ready_o drops on the 4th byte of operand 2 only. Operand 1 = 32'h5 is held stable, followed in order by 6 and 7, with last on 7.
- **Unknown opcode:** 22 00 08 00 AA BB CC DD, then a valid add packet → err_o one pulse after byte 3, 4 payload bytes consumed, no op_valid_o. The following packet yields correct operands.
- **Misaligned length:** 10 00 0A 00 plus 6 bytes → err_o pulse, 6 bytes drained, next opcode byte parsed as an opcode.
- **Reset mid-packet:** rst_i asserted for 1 cycle after 6 bytes of an add packet → all outputs 0. A following fresh packet 11 00 0C 00 03 00 00 00 04 00 00 00 yields 3 and 4.
- **Back-to-back stress:** two 2-operand packets with no idle cycle and op_ready_i = 1 → 4 beats on consecutive operand-completion cycles, rx_ready_o constantly 1.
